// File: rtl/esc_start_seq_if.sv
// Command/status bundle between the ESC start-up sequencer and its environment.
interface esc_start_seq_if #(
  parameter int unsigned DUTY_W = 12
);
  logic              cmd_start;
  logic              cmd_stop;
  logic              cmd_clear;
  logic [DUTY_W-1:0] duty_target;
  logic              run_en;
  logic              fault_latched;
  logic              sw_enable;
  logic              sw_clear_fault;
  logic [DUTY_W-1:0] duty_cmd;
  logic              lowside_only;
  logic [2:0]        state_o;
  logic              busy;

  // Environment side: issues commands, reports latch status, receives drive.
  modport master (
    output cmd_start, cmd_stop, cmd_clear, duty_target, run_en, fault_latched,
    input  sw_enable, sw_clear_fault, duty_cmd, lowside_only, state_o, busy
  );

  // Sequencer side.
  modport slave (
    input  cmd_start, cmd_stop, cmd_clear, duty_target, run_en, fault_latched,
    output sw_enable, sw_clear_fault, duty_cmd, lowside_only, state_o, busy
  );
endinterface

// File: rtl/esc_start_seq.sv
// ESC start-up/run sequencer: enable handshake, bootstrap precharge, rotor
// align, slew-limited duty ramp and run, with immediate drop on trip/stop.
module esc_start_seq #(
  parameter int unsigned DUTY_W        = 12,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned PRECHARGE_CYC = 1000,
  parameter int unsigned ALIGN_CYC     = 5000,
  parameter int unsigned ALIGN_DUTY    = 200,
  parameter int unsigned RAMP_DIV      = 16,
  parameter int unsigned RAMP_STEP     = 1,
  parameter int unsigned EN_TIMEOUT    = 4
) (
  input  logic             clk_ctrl,
  input  logic             rst_ctrl,
  esc_start_seq_if.slave   bus
);

  localparam int unsigned SW = DUTY_W + 1;

  localparam logic [CNT_W-1:0]  EN_LAST    = CNT_W'(EN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST   = CNT_W'(PRECHARGE_CYC - 1);
  localparam logic [CNT_W-1:0]  ALIGN_LAST = CNT_W'(ALIGN_CYC - 1);
  localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(RAMP_DIV - 1);
  localparam logic [DUTY_W-1:0] ALIGN_D    = DUTY_W'(ALIGN_DUTY);
  localparam logic [SW-1:0]     STEP_EXT   = SW'(RAMP_STEP);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENABLE    = 3'd1,
    S_PRECHARGE = 3'd2,
    S_ALIGN     = 3'd3,
    S_RAMP      = 3'd4,
    S_RUN       = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  div_q;
  logic [DUTY_W-1:0] duty_q;
  logic              sw_enable_q;
  logic              clear_q;
  logic              lowside_q;
  logic              busy_q;

  logic [SW-1:0]     duty_ext;
  logic [SW-1:0]     tgt_ext;
  logic [SW-1:0]     up_sum;
  logic [SW-1:0]     dn_dif;
  logic [DUTY_W-1:0] slew_duty;
  logic [DUTY_W-1:0] slew_next;
  logic              step_due;
  logic              trip;

  // One slew step toward the target, clamped so it never passes the target.
  always_comb begin
    duty_ext  = {1'b0, duty_q};
    tgt_ext   = {1'b0, bus.duty_target};
    up_sum    = duty_ext + STEP_EXT;
    dn_dif    = duty_ext - STEP_EXT;
    slew_duty = duty_q;
    if (tgt_ext > duty_ext) begin
      slew_duty = (up_sum >= tgt_ext) ? bus.duty_target : up_sum[DUTY_W-1:0];
    end else if (tgt_ext < duty_ext) begin
      slew_duty = (dn_dif[DUTY_W] || (dn_dif <= tgt_ext)) ? bus.duty_target
                                                           : dn_dif[DUTY_W-1:0];
    end
    step_due  = (div_q == DIV_LAST);
    slew_next = step_due ? slew_duty : duty_q;
    trip      = bus.fault_latched || !bus.run_en;
  end

  // Sequencer state, phase timers and registered drive outputs.
  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      duty_q      <= '0;
      sw_enable_q <= 1'b0;
      clear_q     <= 1'b0;
      lowside_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      cnt_q   <= cnt_q + CNT_W'(1);
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_clear) clear_q <= 1'b1;
          if (bus.cmd_start && !bus.fault_latched) begin
            state_q     <= S_ENABLE;
            sw_enable_q <= 1'b1;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
          end
        end
        S_ENABLE: begin
          if (bus.fault_latched || (!bus.cmd_stop && !bus.run_en && cnt_q == EN_LAST)) begin
            state_q <= S_FAULT; sw_enable_q <= 1'b0; duty_q <= '0;
            lowside_q <= 1'b0; busy_q <= 1'b0; cnt_q <= '0;
          end else if (bus.cmd_stop) begin
            state_q <= S_IDLE; sw_enable_q <= 1'b0; duty_q <= '0;
            lowside_q <= 1'b0; busy_q <= 1'b0; cnt_q <= '0;
          end else if (bus.run_en) begin
            state_q   <= S_PRECHARGE;
            lowside_q <= 1'b1;
            duty_q    <= '0;
            cnt_q     <= '0;
          end
        end
        S_PRECHARGE, S_ALIGN, S_RAMP, S_RUN: begin
          if (trip) begin
            state_q <= S_FAULT; sw_enable_q <= 1'b0; duty_q <= '0;
            lowside_q <= 1'b0; busy_q <= 1'b0; cnt_q <= '0;
          end else if (bus.cmd_stop) begin
            state_q <= S_IDLE; sw_enable_q <= 1'b0; duty_q <= '0;
            lowside_q <= 1'b0; busy_q <= 1'b0; cnt_q <= '0;
          end else if (state_q == S_PRECHARGE) begin
            if (cnt_q == PRE_LAST) begin
              state_q   <= S_ALIGN;
              lowside_q <= 1'b0;
              duty_q    <= ALIGN_D;
              cnt_q     <= '0;
            end
          end else if (state_q == S_ALIGN) begin
            if (cnt_q == ALIGN_LAST) begin
              state_q <= S_RAMP;
              div_q   <= '0;
              cnt_q   <= '0;
            end
          end else begin
            div_q  <= step_due ? '0 : div_q + CNT_W'(1);
            duty_q <= slew_next;
            if (state_q == S_RAMP && slew_next == bus.duty_target) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
            end
          end
        end
        S_FAULT: begin
          if (bus.cmd_clear) begin
            clear_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE; sw_enable_q <= 1'b0; duty_q <= '0;
          lowside_q <= 1'b0; busy_q <= 1'b0; cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.sw_enable      = sw_enable_q;
  assign bus.sw_clear_fault = clear_q;
  assign bus.duty_cmd       = duty_q;
  assign bus.lowside_only   = lowside_q;
  assign bus.state_o        = state_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_esc_start_seq.sv
// Bench for esc_start_seq: per-cycle reference model plus directed scenarios.
module tb_esc_start_seq;

  localparam int DW   = 12;
  localparam int PC   = 10;
  localparam int AC   = 20;
  localparam int AD   = 200;
  localparam int DIV  = 4;
  localparam int STEP = 1;
  localparam int ENTO = 4;

  logic clk_ctrl = 1'b0;
  logic rst_ctrl = 1'b0;
  logic latch_ok = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  esc_start_seq_if #(.DUTY_W(DW)) bus_a ();
  esc_start_seq_if #(.DUTY_W(DW)) bus_b ();

  esc_start_seq #(
    .DUTY_W(DW), .CNT_W(20), .PRECHARGE_CYC(PC), .ALIGN_CYC(AC), .ALIGN_DUTY(AD),
    .RAMP_DIV(DIV), .RAMP_STEP(STEP), .EN_TIMEOUT(ENTO)
  ) dut_a (.clk_ctrl(clk_ctrl), .rst_ctrl(rst_ctrl), .bus(bus_a.slave));

  esc_start_seq #(
    .DUTY_W(DW), .CNT_W(20), .PRECHARGE_CYC(2), .ALIGN_CYC(3), .ALIGN_DUTY(200),
    .RAMP_DIV(4), .RAMP_STEP(8), .EN_TIMEOUT(4)
  ) dut_b (.clk_ctrl(clk_ctrl), .rst_ctrl(rst_ctrl), .bus(bus_b.slave));

  always #5 clk_ctrl = ~clk_ctrl;

  // Kill-latch stand-ins: run_en follows sw_enable one cycle later.
  always @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      bus_a.run_en <= 1'b0;
      bus_b.run_en <= 1'b0;
    end else begin
      bus_a.run_en <= latch_ok && bus_a.sw_enable && !bus_a.fault_latched;
      bus_b.run_en <= bus_b.sw_enable && !bus_b.fault_latched;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase timing from entry timestamps, duty as an integer.
  int m_st, m_duty, m_entry, m_ramp_t0, cyc;
  bit m_clr;

  function automatic int slew(input int d, input int tgt);
    int diff;
    diff = tgt - d;
    if (diff > 0) return d + ((diff < STEP) ? diff : STEP);
    if (diff < 0) return d - ((-diff < STEP) ? -diff : STEP);
    return d;
  endfunction

  task automatic m_enter(input int s);
    m_st    = s;
    m_entry = cyc;
    if (s == 4) begin
      m_duty    = AD;
      m_ramp_t0 = cyc;
    end
  endtask

  always @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      m_st = 0; m_duty = 0; m_clr = 0; cyc = 0; m_entry = 0; m_ramp_t0 = 0;
    end else begin
      cyc++;
      m_clr = 0;
      case (m_st)
        0: begin
          if (bus_a.cmd_clear) m_clr = 1;
          if (bus_a.cmd_start && !bus_a.fault_latched) m_enter(1);
        end
        1: begin
          if (bus_a.fault_latched) m_enter(6);
          else if (bus_a.cmd_stop) m_enter(0);
          else if (bus_a.run_en) m_enter(2);
          else if (cyc - m_entry == ENTO) m_enter(6);
        end
        2, 3: begin
          if (bus_a.fault_latched || !bus_a.run_en) m_enter(6);
          else if (bus_a.cmd_stop) m_enter(0);
          else if (cyc - m_entry == ((m_st == 2) ? PC : AC)) m_enter(m_st + 1);
        end
        4, 5: begin
          if (bus_a.fault_latched || !bus_a.run_en) m_enter(6);
          else if (bus_a.cmd_stop) m_enter(0);
          else begin
            if ((cyc - m_ramp_t0) % DIV == 0) m_duty = slew(m_duty, int'(bus_a.duty_target));
            if (m_st == 4 && m_duty == int'(bus_a.duty_target)) m_enter(5);
          end
        end
        default: begin
          if (bus_a.cmd_clear) begin
            m_clr = 1;
            m_enter(0);
          end
        end
      endcase
    end
  end

  // Per-cycle comparison of instance A against the model.
  always @(negedge clk_ctrl) begin
    if (cmp_en && !rst_ctrl) begin
      chk("m_state",  int'(bus_a.state_o), m_st);
      chk("m_enable", int'(bus_a.sw_enable), (m_st >= 1 && m_st <= 5) ? 1 : 0);
      chk("m_busy",   int'(bus_a.busy), (m_st >= 1 && m_st <= 5) ? 1 : 0);
      chk("m_lowside", int'(bus_a.lowside_only), (m_st == 2) ? 1 : 0);
      chk("m_clear",  int'(bus_a.sw_clear_fault), int'(m_clr));
      chk("m_duty",   int'(bus_a.duty_cmd),
          (m_st == 3) ? AD : ((m_st == 4 || m_st == 5) ? m_duty : 0));
    end
  end

  int b_max = 0;
  int b_min = 4095;
  bit b_trk = 1'b0;
  always @(negedge clk_ctrl) begin
    if (b_trk && bus_b.state_o >= 3'd4) begin
      if (int'(bus_b.duty_cmd) > b_max) b_max = int'(bus_b.duty_cmd);
      if (int'(bus_b.duty_cmd) < b_min) b_min = int'(bus_b.duty_cmd);
    end
  end

  task automatic pulse_a(input int which);
    @(negedge clk_ctrl);
    case (which)
      0: bus_a.cmd_start = 1'b1;
      1: bus_a.cmd_stop  = 1'b1;
      default: bus_a.cmd_clear = 1'b1;
    endcase
    @(negedge clk_ctrl);
    bus_a.cmd_start = 1'b0;
    bus_a.cmd_stop  = 1'b0;
    bus_a.cmd_clear = 1'b0;
  endtask

  task automatic wait_state(input string name, input int s, input int limit);
    int n;
    n = 0;
    while (int'(bus_a.state_o) != s && n < limit) begin
      @(negedge clk_ctrl);
      n++;
    end
    chk(name, int'(bus_a.state_o), s);
  endtask

  task automatic count_state(input int s, output int n);
    n = 0;
    while (int'(bus_a.state_o) == s && n < 200) begin
      n++;
      @(negedge clk_ctrl);
    end
  endtask

  int n;

  initial begin
    bus_a.cmd_start = 0; bus_a.cmd_stop = 0; bus_a.cmd_clear = 0;
    bus_a.fault_latched = 0; bus_a.duty_target = '0;
    bus_b.cmd_start = 0; bus_b.cmd_stop = 0; bus_b.cmd_clear = 0;
    bus_b.fault_latched = 0; bus_b.duty_target = '0;
    #2 rst_ctrl = 1'b1;
    @(negedge clk_ctrl);
    chk("rst_state", int'(bus_a.state_o), 0);
    chk("rst_duty", int'(bus_a.duty_cmd), 0);
    chk("rst_en", int'(bus_a.sw_enable) + int'(bus_a.busy) + int'(bus_a.lowside_only), 0);
    rst_ctrl = 1'b0;
    cmp_en = 1'b1;

    // Nominal start to 210.
    bus_a.duty_target = 12'd210;
    pulse_a(0);
    chk("start_state", int'(bus_a.state_o), 1);
    chk("start_en", int'(bus_a.sw_enable), 1);
    wait_state("to_pre", 2, 10);
    chk("pre_lowside", int'(bus_a.lowside_only), 1);
    count_state(2, n);
    chk("pre_len", n, 10);
    chk("align_duty", int'(bus_a.duty_cmd), 200);
    count_state(3, n);
    chk("align_len", n, 20);
    count_state(4, n);
    chk("ramp_len", n, 40);
    chk("run_state", int'(bus_a.state_o), 5);
    chk("run_duty", int'(bus_a.duty_cmd), 210);

    // Downward tracking in RUN.
    bus_a.duty_target = 12'd205;
    repeat (30) @(negedge clk_ctrl);
    chk("down_duty", int'(bus_a.duty_cmd), 205);
    pulse_a(1);
    chk("stop_state", int'(bus_a.state_o), 0);
    chk("stop_duty", int'(bus_a.duty_cmd), 0);

    // Trip during RAMP, start ignored in FAULT, clear back to IDLE.
    bus_a.duty_target = 12'd250;
    pulse_a(0);
    wait_state("to_ramp", 4, 100);
    repeat (3) @(negedge clk_ctrl);
    bus_a.fault_latched = 1'b1;
    @(negedge clk_ctrl);
    chk("trip_state", int'(bus_a.state_o), 6);
    chk("trip_en", int'(bus_a.sw_enable), 0);
    chk("trip_duty", int'(bus_a.duty_cmd), 0);
    bus_a.fault_latched = 1'b0;
    pulse_a(0);
    chk("fault_hold", int'(bus_a.state_o), 6);
    pulse_a(2);
    chk("clr_pulse", int'(bus_a.sw_clear_fault), 1);
    chk("clr_state", int'(bus_a.state_o), 0);
    @(negedge clk_ctrl);
    chk("clr_once", int'(bus_a.sw_clear_fault), 0);

    // Enable timeout with a dead latch.
    latch_ok = 1'b0;
    pulse_a(0);
    count_state(1, n);
    chk("en_len", n, 4);
    chk("en_fault", int'(bus_a.state_o), 6);
    latch_ok = 1'b1;
    pulse_a(2);

    // Stop + fault on the last ALIGN cycle: fault wins.
    pulse_a(0);
    wait_state("to_align1", 3, 50);
    repeat (19) @(negedge clk_ctrl);
    chk("last_align1", int'(bus_a.state_o), 3);
    bus_a.cmd_stop = 1'b1; bus_a.fault_latched = 1'b1;
    @(negedge clk_ctrl);
    bus_a.cmd_stop = 1'b0; bus_a.fault_latched = 1'b0;
    chk("sim_fault", int'(bus_a.state_o), 6);
    pulse_a(2);

    // Stop alone on the last ALIGN cycle: back to IDLE.
    pulse_a(0);
    wait_state("to_align2", 3, 50);
    repeat (19) @(negedge clk_ctrl);
    bus_a.cmd_stop = 1'b1;
    @(negedge clk_ctrl);
    bus_a.cmd_stop = 1'b0;
    chk("sim_stop", int'(bus_a.state_o), 0);
    chk("sim_stop_duty", int'(bus_a.duty_cmd), 0);

    // Asynchronous reset mid-PRECHARGE.
    pulse_a(0);
    wait_state("to_pre2", 2, 10);
    repeat (3) @(negedge clk_ctrl);
    #2 rst_ctrl = 1'b1;
    #1;
    chk("arst_state", int'(bus_a.state_o), 0);
    chk("arst_out", int'(bus_a.sw_enable) + int'(bus_a.lowside_only) + int'(bus_a.busy), 0);
    @(negedge clk_ctrl);
    rst_ctrl = 1'b0;
    repeat (10) @(negedge clk_ctrl);
    chk("arst_idle", int'(bus_a.state_o), 0);
    pulse_a(0);
    chk("arst_restart", int'(bus_a.state_o), 1);
    pulse_a(1);

    // Large slew step clamps at the target without overshoot.
    bus_b.duty_target = 12'd203;
    b_trk = 1'b1;
    @(negedge clk_ctrl); bus_b.cmd_start = 1'b1;
    @(negedge clk_ctrl); bus_b.cmd_start = 1'b0;
    n = 0;
    while (bus_b.state_o != 3'd5 && n < 100) begin
      @(negedge clk_ctrl);
      n++;
    end
    chk("b_run", int'(bus_b.state_o), 5);
    chk("b_duty", int'(bus_b.duty_cmd), 203);
    chk("b_no_over", (b_max <= 203) ? 1 : 0, 1);
    bus_b.duty_target = 12'd180;
    repeat (20) @(negedge clk_ctrl);
    chk("b_down", int'(bus_b.duty_cmd), 180);
    chk("b_no_under", (b_min >= 180) ? 1 : 0, 1);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/esc_start_seq.md
# esc_start_seq

Start-up and run sequencer for the ESC power stage, in the `clk_ctrl` domain upstream of the PWM kill/enable latch.
- Owns the software-side enable and fault-clear requests to that latch.
- Walks the inverter through bootstrap precharge, rotor alignment and a slew-limited duty ramp.
- Drops everything to zero the cycle a fault or stop is seen.
- Its duty and mode outputs feed the PWM generator.

## Interface
Parameters:
- `DUTY_W`, 12 — duty command width.
- `CNT_W`, 20 — phase counter width.
- `PRECHARGE_CYC`, 1000 — precharge phase length in cycles; must be ≥ 1.
- `ALIGN_CYC`, 5000 — align phase length in cycles; must be ≥ 1.
- `ALIGN_DUTY`, 200 — duty applied during align.
- `RAMP_DIV`, 16 — cycles per slew step; must be ≥ 1.
- `RAMP_STEP`, 1 — duty change per slew step.
- `EN_TIMEOUT`, 4 — maximum cycles to wait for `run_en` after enabling.

Ports:
- `clk_ctrl`  in  1  control clock.
- `rst_ctrl`  in  1  asynchronous, active-high reset.
- `cmd_start`  in  1  start request, one-cycle pulse.
- `cmd_stop`  in  1  stop request, one-cycle pulse.
- `cmd_clear`  in  1  fault clear request, one-cycle pulse.
- `duty_target`  in  DUTY_W  requested running duty.
- `run_en`  in  1  enable status from the kill latch.
- `fault_latched`  in  1  fault status from the kill latch.
- `sw_enable`  out  1  enable request to the kill latch.
- `sw_clear_fault`  out  1  one-cycle clear pulse to the kill latch.
- `duty_cmd`  out  DUTY_W  duty to the PWM generator.
- `lowside_only`  out  1  PWM mode: all low-side switches on, high-side off.
- `state_o`  out  3  current state code.
- `busy`  out  1  high whenever `state_o` is neither IDLE nor FAULT.

## Operation
All outputs are registered. Reset values: `sw_enable`=0, `sw_clear_fault`=0, `duty_cmd`=0, `lowside_only`=0, `state_o`=IDLE, `busy`=0.

State codes and per-state behaviour:
- **IDLE (0)**
  - `sw_enable`=0, `duty_cmd`=0.
  - `cmd_start` with `fault_latched`=0 → ENABLE. `cmd_start` with `fault_latched`=1 is ignored.
  - `cmd_clear` → one-cycle pulse on `sw_clear_fault`; state stays IDLE.
- **ENABLE (1)**
  - `sw_enable`=1.
  - `run_en`=1 → PRECHARGE.
  - `run_en` still 0 after `EN_TIMEOUT` cycles in ENABLE → FAULT.
- **PRECHARGE (2)**
  - `lowside_only`=1, `duty_cmd`=0.
  - Lasts exactly `PRECHARGE_CYC` cycles, then → ALIGN.
- **ALIGN (3)**
  - `lowside_only`=0, `duty_cmd`=`ALIGN_DUTY`.
  - Lasts exactly `ALIGN_CYC` cycles, then → RAMP.
- **RAMP (4)**
  - Every `RAMP_DIV`-th cycle, `duty_cmd` moves toward `duty_target` by `RAMP_STEP`, up or down.
  - The step is clamped so `duty_cmd` never overshoots `duty_target`.
  - When `duty_cmd` == `duty_target` → RUN.
- **RUN (5)**
  - Same slew rule as RAMP, so target changes are tracked with rate limiting.
  - State stays RUN.
- **FAULT (6)**
  - `sw_enable`=0, `duty_cmd`=0, `lowside_only`=0.
  - `cmd_clear` → one-cycle `sw_clear_fault` pulse, then → IDLE.

Trip rules:
- In PRECHARGE, ALIGN, RAMP or RUN, either `fault_latched`=1 or `run_en`=0 → FAULT.
- In ENABLE, `fault_latched`=1 → FAULT.
- On any entry to FAULT, `sw_enable`, `duty_cmd` and `lowside_only` are 0 on the next edge.

`cmd_stop` in any busy state → IDLE, with all drive outputs 0 on the next edge.

Priority when events coincide in the same cycle: fault/trip > `cmd_stop` > phase-timer expiry / `cmd_start`.

Counters:
- The phase counter reloads on every state entry.
- The slew divider clears on RAMP entry and runs freely through RAMP and RUN.

Arithmetic:
- The slew computation uses a `DUTY_W`+1-bit intermediate.
- Results are clamped to [0, 2^DUTY_W−1] and to `duty_target`.

## Timing
- `cmd_start` at edge N → `sw_enable`=1 and `state_o`=ENABLE at N+1.
- The kill latch returns `run_en` one cycle after `sw_enable`. With a healthy latch, PRECHARGE is entered at N+3.
- `state_o`=PRECHARGE for exactly `PRECHARGE_CYC` consecutive cycles; ALIGN for exactly `ALIGN_CYC`.
- First ramp step lands `RAMP_DIV` cycles after RAMP entry.
- Trip seen at edge M → `sw_enable`=0 and `duty_cmd`=0 at M+1. This is independent of the kill latch's own gating.
- `sw_clear_fault` is high for exactly one cycle per accepted `cmd_clear`.
- Asynchronous reset mid-sequence forces all outputs to their reset values immediately. The block restarts in IDLE; no pending command is remembered.

## Test plan
1. **Nominal start.**
   - Parameters: `PRECHARGE_CYC`=10, `ALIGN_CYC`=20, `ALIGN_DUTY`=200, `RAMP_DIV`=4, `RAMP_STEP`=1; latch model loops `run_en` back one cycle after `sw_enable`.
   - Stimulus: `duty_target`=210, pulse `cmd_start`.
   - Required: PRECHARGE for 10 cycles with `lowside_only`=1, ALIGN for 20 cycles at duty 200, 10 steps of 4 cycles each to 210, then RUN.
2. **Downward ramp and slew cap.**
   - In RUN at 210, set `duty_target`=205 → `duty_cmd` decrements by 1 every 4 cycles and stops at 205.
   - With `RAMP_STEP`=8, a target 3 above `duty_cmd` is reached in a single step with no overshoot.
3. **Trip in RAMP.**
   - Raise `fault_latched` → FAULT next cycle, `sw_enable`=0, `duty_cmd`=0.
   - `cmd_start` while in FAULT is ignored.
   - `cmd_clear` → single-cycle `sw_clear_fault`, then IDLE.
4. **Enable timeout.**
   - Hold `run_en`=0 after start → FAULT after exactly 4 cycles in ENABLE.
5. **Simultaneous events.**
   - Last ALIGN cycle with both `cmd_stop` and `fault_latched` asserted → FAULT, not IDLE or RAMP.
   - Last ALIGN cycle with `cmd_stop` alone → IDLE with `duty_cmd`=0.
6. **Reset mid-sequence.**
   - Assert `rst_ctrl` asynchronously mid-PRECHARGE → all outputs 0 and `state_o`=0 before the next clock edge.
   - After release, IDLE is held until a new `cmd_start`.
